// File: rtl/blk_bb2db6_pkg.sv
// Shared types and constants for the burst responder: FSM states, response
// encodings and the 4 KB page size used for the boundary-crossing check.
package blk_bb2db6_pkg;

    localparam int BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/blk_bb2db6_if.sv
// Burst request, memory read port and beat stream of the burst responder,
// grouped so the requester/memory side and the responder side plug together.
interface blk_bb2db6_if
    import blk_bb2db6_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] in_BURST_ADDR;
    logic [7:0]            in_BURST_LEN;
    logic                  in_BURST_VALID;
    logic                  out_BURST_READY;

    logic [ADDR_WIDTH-1:0] out_MEM_ADDR;
    logic                  out_MEM_RE;
    logic [DATA_WIDTH-1:0] in_MEM_RDATA;

    logic [DATA_WIDTH-1:0] out_DATA;
    logic                  out_DATA_LAST;
    resp_e                 out_DATA_RESP;
    logic                  out_DATA_VALID;
    logic                  in_DATA_READY;
    logic                  out_ERR;

    modport slave (
        input  in_BURST_ADDR, in_BURST_LEN, in_BURST_VALID, in_MEM_RDATA, in_DATA_READY,
        output out_BURST_READY, out_MEM_ADDR, out_MEM_RE,
        output out_DATA, out_DATA_LAST, out_DATA_RESP, out_DATA_VALID, out_ERR
    );

    modport master (
        output in_BURST_ADDR, in_BURST_LEN, in_BURST_VALID, in_MEM_RDATA, in_DATA_READY,
        input  out_BURST_READY, out_MEM_ADDR, out_MEM_RE,
        input  out_DATA, out_DATA_LAST, out_DATA_RESP, out_DATA_VALID, out_ERR
    );

endinterface

// File: rtl/weight_s_loader_wq_weight_s_sum_mmap_m_axi_resp_fifo.sv
// Two-entry output FIFO holding {last, resp, data} beats; the head entry is
// presented combinationally and only moves on a pop.
module weight_s_loader_wq_weight_s_sum_mmap_m_axi_resp_fifo #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // The caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clk_en) begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/blk_bb2db6.sv
// Burst read responder: accepts a burst, issues one memory read per beat and
// streams the returned beats through a small FIFO, flagging 4 KB crossings.
module blk_bb2db6
    import blk_bb2db6_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    blk_bb2db6_if.slave  bus
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int ALIGN      = $clog2(DATA_BYTES);
    localparam int CW         = (13 - ALIGN > 9) ? (13 - ALIGN) : 9;
    localparam int ENTRY_W    = DATA_WIDTH + 3;
    localparam logic [CW-1:0]         LAST_SLOT  = CW'(BOUNDARY_4K / DATA_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            remain_q;
    logic                  burst_err_q;
    logic                  err_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    resp_e                 inflight_resp_q;

    logic [1:0]            fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_valid;
    logic                  accept;
    logic                  issue;
    logic                  pop;
    logic                  crossing;
    logic [2:0]            occupancy;
    logic [CW-1:0]         end_slot;

    assign end_slot   = CW'(bus.in_BURST_ADDR[11:ALIGN]) + CW'(bus.in_BURST_LEN);
    assign crossing   = end_slot > LAST_SLOT;
    assign fifo_valid = fifo_count != 2'd0;
    assign accept     = (state == IDLE) && bus.in_BURST_VALID && clk_en;
    assign pop        = fifo_valid && bus.in_DATA_READY && clk_en;

    // Counting this cycle's pop lets a new read issue while a full FIFO drains,
    // which is what keeps the stream at one beat per cycle.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state == BURST) && clk_en && (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_BURST_VALID) state_next = BURST;
            BURST:   if (issue && remain_q == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.out_BURST_READY = (state == IDLE);
        bus.out_MEM_RE      = issue;
        bus.out_MEM_ADDR    = addr_q;
    end

    // Address/beat bookkeeping plus the one-cycle tag pipeline that matches
    // returning read data with its LAST and RESP tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q          <= '0;
            remain_q        <= 8'd0;
            burst_err_q     <= 1'b0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_resp_q <= RESP_OKAY;
        end else if (clk_en) begin
            if (accept) begin
                addr_q      <= bus.in_BURST_ADDR & ALIGN_MASK;
                remain_q    <= bus.in_BURST_LEN;
                burst_err_q <= crossing;
                if (crossing) err_q <= 1'b1;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_WIDTH'(DATA_BYTES);
                remain_q <= remain_q - 8'd1;
            end
            inflight_q      <= issue;
            inflight_last_q <= (remain_q == 8'd0);
            inflight_resp_q <= burst_err_q ? RESP_SLVERR : RESP_OKAY;
        end
    end

    weight_s_loader_wq_weight_s_sum_mmap_m_axi_resp_fifo #(
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .push      (inflight_q && clk_en),
        .push_data ({inflight_last_q, inflight_resp_q, bus.in_MEM_RDATA}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        bus.out_DATA       = fifo_head[DATA_WIDTH-1:0];
        bus.out_DATA_RESP  = resp_e'(fifo_head[DATA_WIDTH+1:DATA_WIDTH]);
        bus.out_DATA_LAST  = fifo_head[DATA_WIDTH+2];
        bus.out_DATA_VALID = fifo_valid;
        bus.out_ERR        = err_q;
    end

endmodule

// File: tb/tb_blk_bb2db6.sv
// Directed bench for the burst responder: a table of single bursts plus
// hand-written sequences for backpressure, back-to-back, stall and reset.
module tb_blk_bb2db6;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  resp;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [31:0] gotData[$];
    logic        gotLast[$];
    logic [1:0]  gotResp[$];
    int          cycQ[$];
    logic [31:0] issueQ[$];
    beat_t       expQ[$];

    logic        o_ready, o_re, o_valid, o_last, o_err;
    logic [31:0] o_addr, o_data;
    logic [1:0]  o_resp;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;

    vec_t vecs[7];

    blk_bb2db6_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    blk_bb2db6 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: read data appears one enabled cycle after the read strobe.
    always @(posedge clk) begin
        if (clk_en === 1'b1 && bus.out_MEM_RE === 1'b1)
            bus.in_MEM_RDATA <= mem_word(bus.out_MEM_ADDR);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock: set ready/enable, sample outputs mid-cycle, record handshakes.
    task automatic applyStimulus(input logic rdy, input logic en);
        bus.in_DATA_READY = rdy;
        clk_en = en;
        #1;
        o_ready = bus.out_BURST_READY;
        o_re    = bus.out_MEM_RE;
        o_addr  = bus.out_MEM_ADDR;
        o_data  = bus.out_DATA;
        o_valid = bus.out_DATA_VALID;
        o_last  = bus.out_DATA_LAST;
        o_resp  = bus.out_DATA_RESP;
        o_err   = bus.out_ERR;
        if (prev_hold && !reset)
            checkOutput("hold_stable", {31'b0, o_valid, o_data}, {31'b0, 1'b1, prev_data});
        if (en && o_valid && rdy && !reset) begin
            gotData.push_back(o_data);
            gotLast.push_back(o_last);
            gotResp.push_back(o_resp);
            cycQ.push_back(cyc);
        end
        if (en && o_re && !reset) begin
            issueQ.push_back(o_addr);
            checkOutput("ready_low_in_burst", {63'b0, o_ready}, 64'd0);
            checkOutput("outstanding_le2", {63'b0, (issueQ.size() - gotData.size()) <= 2}, 64'd1);
        end
        prev_hold = o_valid && !(rdy && en) && !reset;
        prev_data = o_data;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_queues();
        gotData.delete(); gotLast.delete(); gotResp.delete();
        cycQ.delete(); issueQ.delete(); expQ.delete();
    endtask

    task automatic add_expected(input logic [31:0] addr, input int len, input logic [1:0] resp);
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(i * 4);
            expQ.push_back('{addr: a, data: mem_word(a), last: (i == len), resp: resp});
        end
    endtask

    task automatic send_burst(input logic [31:0] addr, input logic [7:0] len);
        logic accepted = 1'b0;
        bus.in_BURST_ADDR  = addr;
        bus.in_BURST_LEN   = len;
        bus.in_BURST_VALID = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            applyStimulus(1'b1, 1'b1);
            accepted = o_ready;
        end
        bus.in_BURST_VALID = 1'b0;
        checkOutput("burst_accepted", {63'b0, accepted}, 64'd1);
    endtask

    task automatic wait_beats(input int n, input logic toggle);
        for (int i = 0; i < 200 && gotData.size() < n; i++)
            applyStimulus(toggle ? (cyc % 2 == 0) : 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1);
    endtask

    task automatic compare_all(input string name);
        checkOutput({name, " beat_count"}, 64'(gotData.size()), 64'(expQ.size()));
        checkOutput({name, " issue_count"}, 64'(issueQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotData.size(); i++) begin
            checkOutput($sformatf("%s beat%0d data", name, i), {32'b0, gotData[i]}, {32'b0, expQ[i].data});
            checkOutput($sformatf("%s beat%0d last", name, i), {63'b0, gotLast[i]}, {63'b0, expQ[i].last});
            checkOutput($sformatf("%s beat%0d resp", name, i), {62'b0, gotResp[i]}, {62'b0, expQ[i].resp});
        end
        for (int i = 0; i < expQ.size() && i < issueQ.size(); i++)
            checkOutput($sformatf("%s read%0d addr", name, i), {32'b0, issueQ[i]}, {32'b0, expQ[i].addr});
    endtask

    initial begin
        logic [31:0] snap_data, snap_addr;
        logic [3:0]  snap_ctl;

        vecs[0] = '{32'h0000_0100, 8'd3, 2'b00, 1'b0};
        vecs[1] = '{32'h0000_0103, 8'd0, 2'b00, 1'b0};
        vecs[2] = '{32'h0000_0FF0, 8'd3, 2'b00, 1'b0};
        vecs[3] = '{32'h0000_1FFC, 8'd0, 2'b00, 1'b0};
        vecs[4] = '{32'h0000_0FF8, 8'd3, 2'b10, 1'b1};
        vecs[5] = '{32'h0000_2000, 8'd1, 2'b00, 1'b1};
        vecs[6] = '{32'hFFFF_FFFC, 8'd2, 2'b10, 1'b1};

        reset = 1'b1;
        clk_en = 1'b1;
        bus.in_BURST_VALID = 1'b0;
        bus.in_BURST_ADDR  = 32'h0;
        bus.in_BURST_LEN   = 8'd0;
        bus.in_DATA_READY  = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst burst_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("rst mem_re", {63'b0, o_re}, 64'd0);
        checkOutput("rst data_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("rst err", {63'b0, o_err}, 64'd0);
        checkOutput("rst data", {32'b0, o_data}, 64'd0);
        checkOutput("rst mem_addr", {32'b0, o_addr}, 64'd0);

        foreach (vecs[k]) begin
            clear_queues();
            add_expected(vecs[k].addr, int'(vecs[k].len), vecs[k].resp);
            send_burst(vecs[k].addr, vecs[k].len);
            wait_beats(int'(vecs[k].len) + 1, 1'b0);
            compare_all($sformatf("vec%0d", k));
            checkOutput($sformatf("vec%0d err", k), {63'b0, o_err}, {63'b0, vecs[k].err});
            if (cycQ.size() == int'(vecs[k].len) + 1)
                checkOutput($sformatf("vec%0d back_to_back_beats", k),
                            64'(cycQ[cycQ.size()-1] - cycQ[0]), 64'(vecs[k].len));
        end

        // Ready toggling every cycle on an 8-beat burst.
        clear_queues();
        add_expected(32'h400, 7, 2'b00);
        send_burst(32'h400, 8'd7);
        wait_beats(8, 1'b1);
        compare_all("toggle");

        // Single-beat burst immediately followed by a two-beat burst.
        clear_queues();
        add_expected(32'h500, 0, 2'b00);
        add_expected(32'h600, 1, 2'b00);
        send_burst(32'h500, 8'd0);
        send_burst(32'h600, 8'd1);
        wait_beats(3, 1'b0);
        compare_all("b2b");

        // Enable dropped for three cycles mid-burst.
        clear_queues();
        add_expected(32'h700, 5, 2'b00);
        send_burst(32'h700, 8'd5);
        for (int i = 0; i < 50 && gotData.size() < 2; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        snap_data = o_data;
        snap_addr = o_addr;
        snap_ctl  = {o_ready, o_valid, o_last, o_err};
        checkOutput("freeze mem_re", {63'b0, o_re}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, (i == 2));
            checkOutput($sformatf("freeze%0d data", i), {32'b0, o_data}, {32'b0, snap_data});
            checkOutput($sformatf("freeze%0d addr", i), {32'b0, o_addr}, {32'b0, snap_addr});
            checkOutput($sformatf("freeze%0d ctl", i), {60'b0, o_ready, o_valid, o_last, o_err}, {60'b0, snap_ctl});
        end
        wait_beats(6, 1'b0);
        compare_all("stall");

        // Reset after two beats of an eight-beat burst, then a fresh burst.
        clear_queues();
        send_burst(32'h800, 8'd7);
        for (int i = 0; i < 50 && gotData.size() < 2; i++) applyStimulus(1'b1, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        reset = 1'b0;
        clear_queues();
        applyStimulus(1'b1, 1'b1);
        checkOutput("midrst data_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("midrst burst_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("midrst err", {63'b0, o_err}, 64'd0);
        repeat (4) applyStimulus(1'b1, 1'b1);
        checkOutput("midrst stale_beats", 64'(gotData.size()), 64'd0);
        clear_queues();
        add_expected(32'h900, 2, 2'b00);
        send_burst(32'h900, 8'd2);
        wait_beats(3, 1'b0);
        compare_all("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blk_bb2db6.md
WEIGHT_S_LOADER_WQ_WEIGHT_S_SUM_MMAP_M_AXI_BURST_RESPONDER -- requirements
Module: weight_s_loader_wq_weight_s_sum_mmap_m_axi_burst_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data beat width in bits (power of 2, >=32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have ports clk input 1 (one clock) and reset input 1 (synchronous, active-high).
REQ-004 SHALL have port clk_en input 1, meaning global enable; all state holds when low.
REQ-005 SHALL have ports in_BURST_ADDR input ADDR_WIDTH, in_BURST_LEN input 8 (beats minus 1), in_BURST_VALID input 1, and out_BURST_READY output 1.
REQ-006 SHALL have ports out_MEM_ADDR output ADDR_WIDTH, out_MEM_RE output 1, and in_MEM_RDATA input DATA_WIDTH, where read data is valid exactly one enabled cycle after out_MEM_RE.
REQ-007 SHALL have ports out_DATA output DATA_WIDTH, out_DATA_LAST output 1, out_DATA_RESP output 2 (00 OKAY, 10 SLVERR), out_DATA_VALID output 1, and in_DATA_READY input 1.
REQ-008 SHALL have port out_ERR output 1, meaning sticky 4 KB-crossing error seen.

Function
REQ-009 SHALL implement FSM states IDLE and BURST; out_BURST_READY = 1 only in IDLE.
REQ-010 SHALL, on in_BURST_VALID & out_BURST_READY & clk_en, latch address aligned down to DATA_WIDTH/8 bytes, latch remaining-beat count = in_BURST_LEN, and enter BURST.
REQ-011 SHALL compute crossing = (addr[11:ALIGN] + in_BURST_LEN) > (4096/DATA_BYTES - 1) at acceptance, using a width of 13-ALIGN bits without overflow.
REQ-012 SHALL, when crossing, tag every beat of that burst with RESP=10 and set out_ERR; it SHALL still return len+1 beats at linearly incrementing addresses.
REQ-013 SHALL assert out_MEM_RE in BURST when clk_en and (fifo_count + inflight) < 2, with out_MEM_ADDR = current address; address SHALL increment by DATA_BYTES per issue, wrapping modulo 2^ADDR_WIDTH.
REQ-014 SHALL, on issuing the final beat (remaining count 0), return to IDLE on the next cycle; a new burst SHALL NOT be accepted in the same cycle as the final issue.
REQ-015 SHALL capture in_MEM_RDATA with its LAST and RESP tags into a 2-entry output FIFO one enabled cycle after issue; the FIFO SHALL never overflow.
REQ-016 SHALL drive out_DATA/LAST/RESP from the FIFO head; out_DATA_VALID = FIFO non-empty; a pop occurs on out_DATA_VALID & in_DATA_READY & clk_en.
REQ-017 SHALL support simultaneous push and pop with count unchanged; held out_DATA SHALL remain stable while valid and not ready.
REQ-018 SHALL sustain one beat per cycle when in_DATA_READY is continuously high (first beat 2 cycles after acceptance).
REQ-019 SHALL assert out_DATA_LAST on exactly the (len+1)-th beat of each burst; beats of consecutive bursts SHALL remain in order.

Reset
REQ-020 SHALL, on reset, enter IDLE and clear FIFO, inflight flag, counters, and out_ERR; outputs SHALL be out_BURST_READY=1 from the first cycle after reset, out_MEM_RE=0, out_DATA_VALID=0, out_ERR=0, and data/address outputs=0.
REQ-021 SHALL, on reset mid-burst, discard all pending beats, and in-flight read data returning after reset SHALL be ignored.

Structure
REQ-022 SHALL place RESP encodings (OKAY, SLVERR) and the 4 KB boundary constant in the shared package.
REQ-023 SHALL use one sub-module for the 2-entry FIFO, named weight_s_loader_wq_weight_s_sum_mmap_m_axi_resp_fifo.

Verification
REQ-024 SHALL cover: addr=0x100, len=3, DATA_WIDTH=32, ready=1 -> reads at 0x100,0x104,0x108,0x10C, 4 beats RESP=00, LAST on beat 4, out_ERR=0.
REQ-025 SHALL cover: addr=0xFF8, len=3 -> 4 beats RESP=10, LAST on beat 4, out_ERR=1 sticky until reset.
REQ-026 SHALL cover: len=7 with in_DATA_READY toggling 1-0 each cycle -> no lost, duplicated, or reordered beats; out_MEM_RE throttled; FIFO count <=2.
REQ-027 SHALL cover: back-to-back bursts len=0 then len=1 -> 3 beats, LAST on beats 1 and 3, out_BURST_READY low during each BURST.
REQ-028 SHALL cover: clk_en low for 3 cycles mid-burst -> all outputs and state frozen, stream resumes unchanged.
REQ-029 SHALL cover: reset asserted after 2 of 8 beats -> out_DATA_VALID=0 next cycle, IDLE, then a fresh burst returns correct data.
